// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and FSM encoding for the two-port memory arbiter.
// Contents: default word-address and data widths, and the IDLE/ISSUE state type.
package mem_pkg;
  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 32;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered priority pointer.
// Ports: i_clk, i_rst_n (sync, active-low), i_req[1:0] eligible requests,
//        o_gnt[1:0] one-hot combinational winner (zero when nothing requests).
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  // r_prio names the favoured port when both request.
  logic r_prio;
  always_comb o_gnt = (&i_req) ? (r_prio ? 2'b10 : 2'b01) : i_req;
  // After a grant, favour the other port: port 0 winning sets the favour to port 1.
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_prio <= 1'b0;
    else if (|i_req) r_prio <= o_gnt[0];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one asynchronous-read RAM between two ports.
// Ports: i_clk, i_rst_n (sync, active-low);
//        per port p: i_req/i_we/i_addr/i_data request, o_gnt access pulse,
//        o_valid read-data pulse, o_rdata held read data;
//        RAM side: o_mem_we, o_mem_addr, o_mem_data, i_mem_spo (async read data).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_valid0,
  output logic              o_valid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_spo
);
  state_t            r_state;
  logic [1:0]        r_gnt, r_valid, w_elig, w_win;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_rdata0, r_rdata1;
  logic              w_rd_done;
  // A port being served this cycle cannot win the next slot; its held Req
  // would otherwise repeat the access it is receiving right now.
  assign w_elig = {i_req1 & ~r_gnt[1], i_req0 & ~r_gnt[0]};
  assign w_rd_done = (r_state == ISSUE) && !r_mem_we;
  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (w_elig),
    .o_gnt   (w_win)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= 2'b00;
      r_valid  <= 2'b00;
      r_mem_we <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= (|w_elig) ? ISSUE : IDLE;
      r_gnt    <= w_win;
      r_mem_we <= w_win[1] ? i_we1 : (w_win[0] & i_we0);
      r_valid  <= w_rd_done ? r_gnt : 2'b00;
      if (w_win[1]) begin
        r_addr <= i_addr1;
        r_data <= i_data1;
      end else if (w_win[0]) begin
        r_addr <= i_addr0;
        r_data <= i_data0;
      end
      if (w_rd_done && r_gnt[0]) r_rdata0 <= i_mem_spo;
      if (w_rd_done && r_gnt[1]) r_rdata1 <= i_mem_spo;
    end
  assign o_gnt0     = r_gnt[0];
  assign o_gnt1     = r_gnt[1];
  assign o_valid0   = r_valid[0];
  assign o_valid1   = r_valid[1];
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_addr;
  assign o_mem_data = r_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [5:0]  addr [2];
  logic [31:0] data [2];
  logic        gnt0, gnt1, valid0, valid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_data, spo;
  logic [5:0]  mem_addr;
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  int          tests = 0, fails = 0;

  // Model state: port granted in the current cycle (-1 none), its command,
  // port whose Valid is expected now, expected held read data, last served port.
  int          g = -1, vld = -1, last = 1;
  bit          g_rd, g_we;
  logic [5:0]  g_addr = '0;
  logic [31:0] g_data = '0, g_val = '0;
  logic [31:0] rd [2];

  always #5 clk = ~clk;

  assign spo = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;

  mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_data0(data[0]), .i_data1(data[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_valid0(valid0), .o_valid1(valid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_spo(spo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model by the rules for the edge, then compare.
  task automatic step();
    bit e0, e1;
    int w;
    if (!rst_n) begin
      g = -1; vld = -1; last = 1; g_we = 0; g_addr = '0; g_data = '0;
      rd[0] = '0; rd[1] = '0;
    end else begin
      vld = (g >= 0 && g_rd) ? g : -1;
      if (vld >= 0) rd[vld] = g_val;
      e0 = req[0] && g != 0;
      e1 = req[1] && g != 1;
      w = (e0 && e1) ? 1 - last : e0 ? 0 : e1 ? 1 : -1;
      if (w >= 0) begin
        last = w; g_we = we[w]; g_rd = !we[w]; g_addr = addr[w]; g_data = data[w];
        g_val = ref_mem[g_addr];
        if (g_we) ref_mem[g_addr] = g_data;
      end
      g = w;
    end
    @(posedge clk); #1;
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    chk("mem_we", 32'(mem_we), 32'(g >= 0 && g_we));
    chk("mem_addr", 32'(mem_addr), 32'(g_addr));
    chk("mem_data", mem_data, g_data);
    chk("valid0", 32'(valid0), 32'(vld == 0));
    chk("valid1", 32'(valid1), 32'(vld == 1));
    chk("rdata0", rdata0, rd[0]);
    chk("rdata1", rdata1, rd[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int p, input bit w, input logic [5:0] a, input logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; data[p] = d;
  endtask

  initial begin
    logic [31:0] pre;
    rd[0] = '0; rd[1] = '0;
    addr[0] = '0; addr[1] = '0; data[0] = '0; data[1] = '0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    do_reset();

    // Port 0 writes, port 1 reads it back.
    set_req(0, 1, 6'd5, 32'hDEADBEEF);
    step();
    req[0] = 1'b0;
    set_req(1, 0, 6'd5, 32'h0);
    step();
    req[1] = 1'b0;
    step();
    chk("wr_rd_rdata1", rdata1, 32'hDEADBEEF);
    step();

    // Both request continuously: port 0 first, then strict alternation.
    do_reset();
    set_req(0, 0, 6'd1, 32'h0);
    set_req(1, 0, 6'd2, 32'h0);
    step();
    chk("alt_first_gnt0", 32'(gnt0), 32'd1);
    for (int i = 0; i < 7; i++) step();
    req = 2'b00;
    step(); step();

    // Port 1 holds a read of address 63.
    set_req(1, 0, 6'd63, 32'h0);
    for (int i = 0; i < 8; i++) step();
    chk("hold_rdata1_63", rdata1, ref_mem[63]);
    req = 2'b00;
    step(); step();

    // Reset lands while a port 0 read is being issued.
    do_reset();
    set_req(0, 0, 6'd5, 32'h0);
    step();
    rst_n = 1'b0; req = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_issue_rdata0", rdata0, 32'd0);
    chk("rst_issue_valid0", 32'(valid0), 32'd0);

    // A one-cycle port 0 write request loses to port 1 and is abandoned.
    set_req(0, 1, 6'd10, 32'hA5A5A5A5);
    step();
    req[0] = 1'b0;
    pre = ram[9];
    set_req(0, 1, 6'd9, 32'h12345678);
    set_req(1, 0, 6'd9, 32'h0);
    step();
    chk("drop_gnt1", 32'(gnt1), 32'd1);
    req = 2'b00;
    step(); step(); step();
    chk("drop_no_write", ram[9], pre);

    // Random two-port traffic over a small address window.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (req[p] && g == p) begin
          if ($urandom_range(1, 0) == 1) set_req(p, 1'($urandom_range(1, 0)), 6'($urandom_range(7, 0)), $urandom);
          else req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(2, 0) == 0)
          set_req(p, 1'($urandom_range(1, 0)), 6'($urandom_range(7, 0)), $urandom);
      end
      step();
    end
    req = 2'b00;
    step(); step(); step();
    for (int i = 0; i < 8; i++) chk("final_ram", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
